// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate-extension stage.
// Mode codes and the parameter sanity check.
package imm_extend_pipe_pkg;

  localparam logic [1:0] MODE_SEXT      = 2'd0;
  localparam logic [1:0] MODE_ZEXT      = 2'd1;
  localparam logic [1:0] MODE_UPPER     = 2'd2;
  localparam logic [1:0] MODE_SEXT_SHL2 = 2'd3;

  function automatic bit width_ok(int in_w, int out_w);
    return (in_w >= 1) && (out_w >= in_w + 2);
  endfunction

endpackage

// File: rtl/imm_extend_pipe_ext_core.sv
// Combinational immediate extender.
// Produces SEXT, ZEXT, UPPER or SEXT<<2 of the input.
module ext_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  data,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] result
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;

  assign sext  = {{(OUT_W-IN_W){data[IN_W-1]}}, data};
  assign zext  = {{(OUT_W-IN_W){1'b0}}, data};
  assign upper = {data, {(OUT_W-IN_W){1'b0}}};

  always_comb begin
    result = sext;
    unique case (1'b1)
      mode == MODE_SEXT:      result = sext;
      mode == MODE_ZEXT:      result = zext;
      mode == MODE_UPPER:     result = upper;
      mode == MODE_SEXT_SHL2: result = {sext[OUT_W-3:0], 2'b00};
      default:                result = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with valid/ready.
// SKID=1 adds a second entry so in_ready comes from a flop.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
);

  if (!width_ok(IN_W, OUT_W)) begin : g_bad_width
    $error("imm_extend_pipe: need IN_W>=1 and OUT_W>=IN_W+2");
  end

  logic [OUT_W-1:0] ext_res;
  logic             m_valid;
  logic [OUT_W-1:0] m_data;
  logic             acc;
  logic             drn;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .data   (in_data),
    .mode   (in_mode),
    .result (ext_res)
  );

  assign acc = in_valid && in_ready;
  assign drn = m_valid && out_ready;

  if (SKID) begin : g_skid
    logic             s_valid;
    logic [OUT_W-1:0] s_data;

    assign in_ready = !s_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_valid <= 1'b0;
        m_data  <= '0;
        s_valid <= 1'b0;
        s_data  <= '0;
      end else if (drn) begin
        // S refills M first; no accept can coincide with a full S
        if (s_valid) begin
          m_data  <= s_data;
          s_valid <= 1'b0;
        end else if (acc) begin
          m_data <= ext_res;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (acc) begin
        if (!m_valid) begin
          m_valid <= 1'b1;
          m_data  <= ext_res;
        end else begin
          s_valid <= 1'b1;
          s_data  <= ext_res;
        end
      end
    end
  end else begin : g_reg
    assign in_ready = !m_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_valid <= 1'b0;
        m_data  <= '0;
      end else if (acc) begin
        m_valid <= 1'b1;
        m_data  <= ext_res;
      end else if (drn) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_neg   = m_data[OUT_W-1];

endmodule
